hk628_audio_out: RTL

- Downstream stage of hk628_core. Consumes its free-running 16-bit signed PCM at the 50 MHz system clock.
- Produces a 48 kHz sample-and-hold stream with volume scaling and click-free soft mute.
- Its output drives AUDIO_L/AUDIO_R in the top-level wrapper.
- Contains a fractional strobe generator, a 4-state mute ramp FSM and a 2-stage arithmetic pipeline.

---
 rtl/hk628_audio_pkg.sv | 41 ++++
 rtl/hk628_rate_strobe.sv | 34 +++
 rtl/hk628_audio_out.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/hk628_audio_pkg.sv
// Shared types and constants for the hk628 audio output stage.
// Ramp helpers saturate at 0 and RAMP_MAX, so the ramp never wraps.
package hk628_audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam int RAMP_W   = 9;
    localparam int RAMP_MAX = 256;

    localparam logic [RAMP_W:0]   RAMP_MAX_W = 10'd256;
    localparam logic [RAMP_W-1:0] RAMP_MAX_R = 9'd256;

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        ACTIVE    = 2'd2,
        RAMP_DOWN = 2'd3
    } ramp_state_t;

    // 10-bit intermediate: worst case is 256 + 256.
    function automatic logic [RAMP_W-1:0] ramp_add(input logic [RAMP_W-1:0] r,
                                                   input logic [RAMP_W:0]   step);
        logic [RAMP_W:0] sum;
        sum = {1'b0, r} + step;
        if (sum >= RAMP_MAX_W) begin
            sum = RAMP_MAX_W;
        end
        return sum[RAMP_W-1:0];
    endfunction

    function automatic logic [RAMP_W-1:0] ramp_sub(input logic [RAMP_W-1:0] r,
                                                   input logic [RAMP_W:0]   step);
        logic [RAMP_W:0] diff;
        if ({1'b0, r} <= step) begin
            diff = '0;
        end else begin
            diff = {1'b0, r} - step;
        end
        return diff[RAMP_W-1:0];
    endfunction

endpackage

// File: rtl/hk628_rate_strobe.sv
// Fractional-rate strobe: phase accumulator that pulses ce SAMPLE_HZ times
// per CLK_HZ cycles on average, with no long-term drift.
module hk628_rate_strobe #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned SAMPLE_HZ = 48_000
) (
    input  logic clk,
    input  logic reset_n,
    output logic ce
);

    localparam logic [32:0] CLK_W  = 33'(CLK_HZ);
    localparam logic [32:0] STEP_W = 33'(SAMPLE_HZ);

    logic [31:0] acc_q;
    logic [31:0] acc_d;
    logic [32:0] acc_sum;
    logic [32:0] acc_wrap;

    // One extra bit so acc + SAMPLE_HZ cannot overflow before the compare.
    assign acc_sum  = {1'b0, acc_q} + STEP_W;
    assign acc_wrap = acc_sum - CLK_W;
    assign ce       = (acc_sum >= CLK_W);
    assign acc_d    = ce ? acc_wrap[31:0] : acc_sum[31:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/hk628_audio_out.sv
// 48 kHz sample-and-hold audio stage: volume scaling and click-free soft mute.
// Pipeline: ce edge captures pcm/vol and steps the ramp, +1 scales, +2 drives.
//
//   state     | meaning
//   MUTED     | ramp held at 0, muted=1
//   RAMP_UP   | ramp climbing by RAMP_STEP per strobe
//   ACTIVE    | ramp held at 256 (unity)
//   RAMP_DOWN | ramp falling by RAMP_STEP per strobe
module hk628_audio_out #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned SAMPLE_HZ = 48_000,
    parameter int unsigned RAMP_STEP = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] pcm_in,
    input  logic [2:0]  vol,
    input  logic        mute,
    output logic [15:0] audio_out,
    output logic        sample_valid,
    output logic        muted
);

    import hk628_audio_pkg::*;

    localparam logic [RAMP_W:0] STEP_W = RAMP_STEP[RAMP_W:0];

    logic ce;

    hk628_rate_strobe #(
        .CLK_HZ   (CLK_HZ),
        .SAMPLE_HZ(SAMPLE_HZ)
    ) u_strobe (
        .clk    (clk),
        .reset_n(reset_n),
        .ce     (ce)
    );

    ramp_state_t       state_q;
    logic [RAMP_W-1:0] ramp_q;
    logic              muted_q;
    logic [RAMP_W-1:0] ramp_inc;
    logic [RAMP_W-1:0] ramp_dec;

    assign ramp_inc = ramp_add(ramp_q, STEP_W);
    assign ramp_dec = ramp_sub(ramp_q, STEP_W);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MUTED;
            ramp_q  <= '0;
            muted_q <= 1'b1;
        end else if (ce) begin
            case (state_q)
                MUTED: begin
                    if (!mute) begin
                        state_q <= RAMP_UP;
                        ramp_q  <= ramp_inc;
                        muted_q <= 1'b0;
                    end else begin
                        ramp_q  <= '0;
                    end
                end
                RAMP_UP: begin
                    if (mute) begin
                        state_q <= RAMP_DOWN;
                        ramp_q  <= ramp_dec;
                    end else begin
                        ramp_q  <= ramp_inc;
                        if (ramp_inc == RAMP_MAX_R) begin
                            state_q <= ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    if (mute) begin
                        state_q <= RAMP_DOWN;
                        ramp_q  <= ramp_dec;
                    end else begin
                        ramp_q  <= RAMP_MAX_R;
                    end
                end
                RAMP_DOWN: begin
                    if (!mute) begin
                        state_q <= RAMP_UP;
                        ramp_q  <= ramp_inc;
                    end else begin
                        ramp_q  <= ramp_dec;
                        if (ramp_dec == '0) begin
                            state_q <= MUTED;
                            muted_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= MUTED;
                    ramp_q  <= '0;
                    muted_q <= 1'b1;
                end
            endcase
        end
    end

    logic signed [SAMPLE_W-1:0] s0_q;
    logic [3:0]                 g0_q;
    logic                       v0_q;
    logic signed [SAMPLE_W-1:0] p1_q;
    logic signed [SAMPLE_W-1:0] p1_d;
    logic [RAMP_W-1:0]          r1_q;
    logic                       v1_q;
    logic signed [SAMPLE_W-1:0] audio_q;
    logic signed [SAMPLE_W-1:0] audio_d;
    logic                       sample_valid_q;

    logic signed [20:0] prod1;
    logic signed [25:0] prod2;

    // Gain is at most 8/8 and ramp at most 256/256, so neither product can exceed 16 bits.
    assign prod1   = s0_q * $signed({1'b0, g0_q});
    assign p1_d    = 16'(prod1 >>> 3);
    assign prod2   = p1_q * $signed({1'b0, r1_q});
    assign audio_d = 16'(prod2 >>> 8);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_q           <= '0;
            g0_q           <= '0;
            v0_q           <= 1'b0;
            p1_q           <= '0;
            r1_q           <= '0;
            v1_q           <= 1'b0;
            audio_q        <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            v0_q           <= ce;
            v1_q           <= v0_q;
            sample_valid_q <= v1_q;
            if (ce) begin
                s0_q <= pcm_in;
                g0_q <= {1'b0, vol} + 4'd1;
            end
            if (v0_q) begin
                p1_q <= p1_d;
                r1_q <= ramp_q;
            end
            if (v1_q) begin
                audio_q <= audio_d;
            end
        end
    end

    assign audio_out    = audio_q;
    assign sample_valid = sample_valid_q;
    assign muted        = muted_q;

endmodule
